// File: rtl/mul_eval_pkg.sv
// Shared definitions for the multiplier error evaluation datapath.
// Default widths, run-control states and the accumulator ceiling.
package mul_eval_pkg;

  localparam int DEF_PW    = 64;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 96;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_error_accumulator_abs_diff_reg.sv
// Stage 1 of the error pipeline: registered |a - b| with its valid.
// The magnitude is taken as larger minus smaller, so it never wraps.
module abs_diff_reg
  import mul_eval_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [PW-1:0] i_a,
  input  logic [PW-1:0] i_b,
  output logic          o_valid,
  output logic [PW-1:0] o_d
);

  logic [PW-1:0] w_d;
  logic          r_v;
  logic [PW-1:0] r_d;

  // Magnitude of the difference between the two products
  always_comb begin
    w_d = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
  end

  // Capture the difference only when a sample is transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else begin
      r_v <= i_valid;
      if (i_valid) r_d <= w_d;
    end
  end

  assign o_valid = r_v;
  assign o_d     = r_d;

endmodule

// File: rtl/mul_error_accumulator.sv
// Streams exact/approximate product pairs and accumulates the
// error sum, maximum error and erroneous-sample count per run.
module mul_error_accumulator
  import mul_eval_pkg::*;
#(
  parameter int PW    = DEF_PW,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    P_exact,
  input  logic [PW-1:0]    P_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_sum,
  output logic [PW-1:0]    err_max,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);

  localparam logic [ACC_W-1:0] L_ACC_MAX = {ACC_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_sum;
  logic [PW-1:0]    r_max;
  logic [CNT_W-1:0] r_ecnt;

  logic             w_ready;
  logic             w_xfer;
  logic             w_last;
  logic             w_start_ok;
  logic             w_v1;
  logic [PW-1:0]    w_d;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_sum_sat;

  assign w_ready    = (r_state == S_RUN) && (r_cnt < r_num);
  assign w_xfer     = in_valid && w_ready;
  assign w_last     = w_xfer && ((r_cnt + CNT_W'(1)) == r_num);
  assign w_start_ok = start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

  abs_diff_reg #(
    .PW(PW)
  ) u_stage1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(w_xfer),
    .i_a    (P_exact),
    .i_b    (P_approx),
    .o_valid(w_v1),
    .o_d    (w_d)
  );

  // Saturating add of the zero-extended stage-1 difference
  always_comb begin
    w_sum_ext = {1'b0, r_sum} + {{(ACC_W + 1 - PW){1'b0}}, w_d};
    w_sum_sat = w_sum_ext[ACC_W] ? L_ACC_MAX : w_sum_ext[ACC_W-1:0];
  end

  // Run control: the final stage-2 update lands on the DRAIN exit edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok)
          w_state_nxt = (num_samples != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_xfer) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Run setup, sample counting and stage-2 accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_max  <= '0;
      r_ecnt <= '0;
    end else if (w_start_ok) begin
      r_num  <= num_samples;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_max  <= '0;
      r_ecnt <= '0;
    end else begin
      if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
      if (w_v1) begin
        r_sum <= w_sum_sat;
        if (w_d > r_max) r_max <= w_d;
        if (w_d != '0)   r_ecnt <= r_ecnt + CNT_W'(1);
      end
    end
  end

  assign in_ready     = w_ready;
  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign err_sum      = r_sum;
  assign err_max      = r_max;
  assign err_count    = r_ecnt;
  assign sample_count = r_cnt;

endmodule

// File: tb/tb_mul_error_accumulator.sv
// Directed bench for mul_error_accumulator: vector table plus
// hand-written sequences for gaps, reset, restart and saturation.
module tb_mul_error_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] P_exact;
  logic [63:0] P_approx;
  logic        busy;
  logic        done;
  logic [95:0] err_sum;
  logic [63:0] err_max;
  logic [31:0] err_count;
  logic [31:0] sample_count;

  logic        s_start;
  logic [31:0] s_num;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_pe;
  logic [63:0] s_pa;
  logic        s_busy;
  logic        s_done;
  logic [65:0] s_sum;
  logic [63:0] s_max;
  logic [31:0] s_ecnt;
  logic [31:0] s_sc;

  int n_chk;
  int n_fail;

  mul_error_accumulator u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .P_exact     (P_exact),
    .P_approx    (P_approx),
    .busy        (busy),
    .done        (done),
    .err_sum     (err_sum),
    .err_max     (err_max),
    .err_count   (err_count),
    .sample_count(sample_count)
  );

  mul_error_accumulator #(
    .ACC_W(66)
  ) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (s_start),
    .num_samples (s_num),
    .in_valid    (s_valid),
    .in_ready    (s_ready),
    .P_exact     (s_pe),
    .P_approx    (s_pa),
    .busy        (s_busy),
    .done        (s_done),
    .err_sum     (s_sum),
    .err_max     (s_max),
    .err_count   (s_ecnt),
    .sample_count(s_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      num;
    logic [3:0][63:0] pe;
    logic [3:0][63:0] pa;
    logic [95:0]      esum;
    logic [63:0]      emax;
    logic [31:0]      ecnt;
  } vec_t;

  vec_t tv[4];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".in_ready"}, 128'(in_ready), 128'd0);
    chk({nm, ".busy"}, 128'(busy), 128'd0);
    chk({nm, ".done"}, 128'(done), 128'd0);
    chk({nm, ".err_sum"}, 128'(err_sum), 128'd0);
    chk({nm, ".err_max"}, 128'(err_max), 128'd0);
    chk({nm, ".err_count"}, 128'(err_count), 128'd0);
    chk({nm, ".sample_count"}, 128'(sample_count), 128'd0);
  endtask

  task automatic chk_res(input string nm, input vec_t v);
    chk({nm, ".err_sum"}, 128'(err_sum), 128'(v.esum));
    chk({nm, ".err_max"}, 128'(err_max), 128'(v.emax));
    chk({nm, ".err_count"}, 128'(err_count), 128'(v.ecnt));
    chk({nm, ".sample_count"}, 128'(sample_count), 128'(v.num));
  endtask

  // Start from IDLE/DONE and stream the vector back-to-back
  task automatic run_vec(input int k);
    vec_t v;
    v = tv[k];
    start = 1'b1;
    num_samples = v.num;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d.busy_run", k), 128'(busy), 128'd1);
    chk($sformatf("v%0d.done_clr", k), 128'(done), 128'd0);
    for (int i = 0; i < int'(v.num); i++) begin
      chk($sformatf("v%0d.ready%0d", k, i), 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      P_exact  = v.pe[i];
      P_approx = v.pa[i];
      tick();
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d.ready_drop", k), 128'(in_ready), 128'd0);
    chk($sformatf("v%0d.busy_drain", k), 128'(busy), 128'd1);
    chk($sformatf("v%0d.done_early", k), 128'(done), 128'd0);
    tick();
    chk($sformatf("v%0d.done", k), 128'(done), 128'd1);
    chk($sformatf("v%0d.busy_off", k), 128'(busy), 128'd0);
    chk_res($sformatf("v%0d", k), v);
    tick();
    chk_res($sformatf("v%0d.hold", k), v);
  endtask

  initial begin
    logic [63:0] ones;
    logic [65:0] sat;
    int          pat[6];
    int          nx;
    ones  = '1;
    sat   = '1;
    n_chk = 0;
    n_fail = 0;

    tv[0] = '0;
    tv[0].num = 4;
    tv[0].pe[0] = 100; tv[0].pa[0] = 100;
    tv[0].pe[1] = 100; tv[0].pa[1] = 96;
    tv[0].pe[2] = 7;   tv[0].pa[2] = 12;
    tv[0].pe[3] = 64'h8000_0000_0000_0000;
    tv[0].pa[3] = 64'h7FFF_FFFF_FFFF_FFFB;
    tv[0].esum = 14; tv[0].emax = 5; tv[0].ecnt = 3;

    tv[1] = '0;
    tv[1].num = 1;
    tv[1].pe[0] = 9; tv[1].pa[0] = 9;

    tv[2] = '0;
    tv[2].num = 2;
    tv[2].pe[0] = 0; tv[2].pa[0] = 5;
    tv[2].pe[1] = 5; tv[2].pa[1] = 0;
    tv[2].esum = 10; tv[2].emax = 5; tv[2].ecnt = 2;

    tv[3] = '0;
    tv[3].num = 3;
    tv[3].pe[0] = ones; tv[3].pa[0] = 0;
    tv[3].pe[1] = 1;    tv[3].pa[1] = 2;
    tv[3].pe[2] = 3;    tv[3].pa[2] = 3;
    tv[3].esum = 96'h1_0000_0000_0000_0000;
    tv[3].emax = ones; tv[3].ecnt = 2;

    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    P_exact = '0;
    P_approx = '0;
    s_start = 1'b0;
    s_num = '0;
    s_valid = 1'b0;
    s_pe = '0;
    s_pa = '0;
    #1;
    chk_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_zero("idle");

    // Zero-length run from IDLE
    start = 1'b1;
    num_samples = 0;
    tick();
    start = 1'b0;
    chk("zero.done", 128'(done), 128'd1);
    chk("zero.busy", 128'(busy), 128'd0);
    chk("zero.ready", 128'(in_ready), 128'd0);
    chk("zero.sum", 128'(err_sum), 128'd0);
    chk("zero.sc", 128'(sample_count), 128'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("zero.busy2", 128'(busy), 128'd0);
    chk("zero.ready2", 128'(in_ready), 128'd0);
    chk("zero.sc2", 128'(sample_count), 128'd0);

    for (int k = 0; k < 4; k++) run_vec(k);

    // Valid gaps, all-ones errors, extra beats after the last transfer
    pat = '{1, 0, 0, 1, 0, 1};
    start = 1'b1;
    num_samples = 3;
    tick();
    start = 1'b0;
    P_exact = 0;
    P_approx = ones;
    nx = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (pat[i] != 0);
      if (in_valid && in_ready) nx++;
      tick();
    end
    chk("gap.xfers", 128'(nx), 128'd3);
    chk("gap.ready_drop", 128'(in_ready), 128'd0);
    chk("gap.sc3", 128'(sample_count), 128'd3);
    in_valid = 1'b1;
    tick();
    chk("gap.done", 128'(done), 128'd1);
    tick();
    in_valid = 1'b0;
    chk("gap.sc_hold", 128'(sample_count), 128'd3);
    chk("gap.sum", 128'(err_sum), 128'h2_FFFF_FFFF_FFFF_FFFD);
    chk("gap.max", 128'(err_max), 128'(ones));
    chk("gap.cnt", 128'(err_count), 128'd3);

    // Start during RUN is ignored; start in DONE restarts
    start = 1'b1;
    num_samples = 3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    P_exact = 10;
    P_approx = 4;
    tick();
    start = 1'b1;
    num_samples = 1;
    P_exact = 1;
    P_approx = 4;
    tick();
    start = 1'b0;
    chk("srun.sc", 128'(sample_count), 128'd2);
    chk("srun.busy", 128'(busy), 128'd1);
    chk("srun.ready", 128'(in_ready), 128'd1);
    chk("srun.sum1", 128'(err_sum), 128'd6);
    P_exact = 0;
    P_approx = 0;
    tick();
    in_valid = 1'b0;
    chk("srun.drain", 128'(busy), 128'd1);
    tick();
    chk("srun.done", 128'(done), 128'd1);
    chk("srun.sum", 128'(err_sum), 128'd9);
    chk("srun.max", 128'(err_max), 128'd6);
    chk("srun.cnt", 128'(err_count), 128'd2);
    chk("srun.sc3", 128'(sample_count), 128'd3);
    start = 1'b1;
    num_samples = 2;
    tick();
    start = 1'b0;
    chk("sdone.done_clr", 128'(done), 128'd0);
    chk("sdone.busy", 128'(busy), 128'd1);
    chk("sdone.sum_clr", 128'(err_sum), 128'd0);
    chk("sdone.sc_clr", 128'(sample_count), 128'd0);
    in_valid = 1'b1;
    P_exact = 2;
    P_approx = 1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    chk("sdone.done", 128'(done), 128'd1);
    chk("sdone.sum", 128'(err_sum), 128'd2);

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    num_samples = 5;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    P_exact = 0;
    P_approx = 7;
    tick();
    tick();
    chk("rst.sc_pre", 128'(sample_count), 128'd2);
    chk("rst.busy_pre", 128'(busy), 128'd1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_zero("rst.mid");
    #2;
    rst_n = 1'b1;
    tick();
    chk_zero("rst.after");
    run_vec(1);

    // Saturation on the 66-bit accumulator instance
    s_start = 1'b1;
    s_num = 8;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_pe = 0;
      s_pa = ones;
      tick();
    end
    s_valid = 1'b0;
    chk("sat.busy", 128'(s_busy), 128'd1);
    tick();
    chk("sat.done", 128'(s_done), 128'd1);
    chk("sat.sum", 128'(s_sum), 128'(sat));
    chk("sat.max", 128'(s_max), 128'(ones));
    chk("sat.cnt", 128'(s_ecnt), 128'd8);
    chk("sat.sc", 128'(s_sc), 128'd8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
